ifetch_queue: RTL and testbench

Parametrised instruction-fetch front end, the successor to the single-cycle PC/NPC + ROM path.
- Holds the fetch PC and reads the combinational instruction ROM once per cycle.
- Buffers {pc, instruction} pairs in a DEPTH-entry prefetch queue.
- Delivers them to decode over a valid/ready handshake.
- Branch/jump redirects from execute flush the queue and restart fetch.

---
 rtl/ifetch_queue_pkg.sv | 20 ++
 rtl/ifetch_queue_if.sv | 26 ++
 rtl/ifetch_fifo.sv | 69 ++++++
 rtl/ifetch_queue.sv | 123 ++++++++++++
 tb/tb_ifetch_queue.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end: reset PC default,
// NOP encoding, word-alignment mask, perf counter width and the queue entry type.
package ifetch_queue_pkg;

  localparam logic [31:0] IFQ_RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] IFQ_NOP              = 32'h0000_0000;
  localparam logic [31:0] IFQ_WORD_MASK        = 32'hFFFF_FFFC;
  localparam int unsigned IFQ_PERF_W           = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a fetch address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & IFQ_WORD_MASK;
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-side bus: instruction ROM port, redirect request from execute and
// the valid/ready delivery channel towards decode.
// master = fetch front end, slave = its environment (ROM, execute, decode).
interface ifetch_queue_if #(
  parameter int unsigned IMEM_AW = 10
);
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_instr;
  logic [31:0]        out_pc;
  logic [31:0]        out_pc4;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, out_pc4,
    input  imem_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, out_pc4,
    output imem_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch_fifo.sv
// DEPTH-entry storage queue of {pc, instr} pairs with push/pop/flush.
// Flush has priority over push/pop; pointers wrap modulo DEPTH (power of two).
module ifetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];

  // Next pointer/count/storage state from flush, push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed through a valid count.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: fetch PC register, reset/redirect/normal
// priority and optional perf counters around an ifetch_fifo prefetch queue.
// Optional feature macro: IFETCH_PERF_CNT_EN (perf counters; ports read 0 otherwise).
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned IMEM_AW  = 10,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,
  ifetch_queue_if.master              bus,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  output logic [IFQ_PERF_W-1:0]       perf_fetch,
  output logic [IFQ_PERF_W-1:0]       perf_stall,
  output logic [IFQ_PERF_W-1:0]       perf_flush
);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  wdata;
  logic          head_valid;
  logic          handshake;
  logic          fifo_push, fifo_pop, fifo_flush;

  assign head_valid = (count != '0);
  assign handshake  = head_valid & bus.out_ready;
  assign wdata      = '{pc: fetch_pc_q, instr: bus.imem_data};

  // Redirect outranks normal fetch; a same-cycle handshake is dropped with the flush.
  always_comb begin
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      fifo_flush = 1'b1;
      fetch_pc_d = word_align(bus.redirect_pc);
    end else begin
      fifo_pop  = handshake;
      fifo_push = (count < CW'(DEPTH)) | handshake;
      if (fifo_push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end
  end

  // Fetch PC register; reset outranks any redirect.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

  assign bus.imem_addr = fetch_pc_q[IMEM_AW+1:2];
  assign bus.out_valid = head_valid;
  assign bus.out_pc    = head_valid ? head.pc : '0;
  assign bus.out_instr = head_valid ? head.instr : IFQ_NOP;
  assign bus.out_pc4   = head_valid ? head.pc + 32'd4 : '0;
  assign level         = count;

`ifdef IFETCH_PERF_CNT_EN
  logic [IFQ_PERF_W-1:0] perf_fetch_q, perf_fetch_d;
  logic [IFQ_PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [IFQ_PERF_W-1:0] perf_flush_q, perf_flush_d;

  // Saturating event counters: pushes, full-and-not-draining cycles, redirects.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (fifo_push && perf_fetch_q != '1) begin
      perf_fetch_d = perf_fetch_q + 1'b1;
    end
    if (count == CW'(DEPTH) && !handshake && perf_stall_q != '1) begin
      perf_stall_d = perf_stall_q + 1'b1;
    end
    if (bus.redirect_valid && perf_flush_q != '1) begin
      perf_flush_d = perf_flush_q + 1'b1;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_fetch = '0;
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (DEPTH=4, IMEM_AW=10, ROM word k = 32'h1000_0000+k).
// Expected perf values follow IFETCH_PERF_CNT_EN.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DP = 4;

  logic        clock;
  logic        reset;
  logic [2:0]  level;
  logic [31:0] perf_fetch, perf_stall, perf_flush;
  int unsigned errors;
  int unsigned checks;

  ifetch_queue_if #(.IMEM_AW(AW)) bus ();

  assign bus.imem_data = 32'h1000_0000 + {{(32-AW){1'b0}}, bus.imem_addr};

  ifetch_queue #(
    .IMEM_AW  (AW),
    .DEPTH    (DP),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.master),
    .level      (level),
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef IFETCH_PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic do_reset();
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    step();
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.out_ready = 1'b0;
    do_reset();

    // Reset state
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_level", {29'b0, level}, 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_pc4", bus.out_pc4, 32'd0);
    chk("rst_addr", {22'b0, bus.imem_addr}, 32'd0);
    chk("rst_pfetch", perf_fetch, 32'd0);

    // Stall: 10 cycles with out_ready=0 from reset release
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("stall_level", {29'b0, level}, (k < 4) ? k : 32'd4);
    end
    chk("stall_addr", {22'b0, bus.imem_addr}, 32'd4);
    chk("stall_pc", bus.out_pc, 32'd0);
    chk("stall_instr", bus.out_instr, 32'h1000_0000);
    chk("stall_pstall", perf_stall, perf_exp(32'd6));
    chk("stall_pfetch", perf_fetch, perf_exp(32'd4));
    // Release: in-order drain with refill
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_pc", bus.out_pc, 32'(4 * i));
      chk("drain_instr", bus.out_instr, 32'h1000_0000 + 32'(i));
      step();
    end

    // Free-run with out_ready=1 from reset release
    do_reset();
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("run_pc", bus.out_pc, 32'(4 * (k - 1)));
      chk("run_instr", bus.out_instr, 32'h1000_0000 + 32'(k - 1));
      chk("run_pc4", bus.out_pc4, 32'(4 * k));
      chk("run_level", {29'b0, level}, 32'd1);
    end

    // Redirect to 0x43 with 3 entries queued
    bus.out_ready = 1'b0;
    do_reset();
    reset = 1'b1;
    step(); step(); step();
    chk("rd_pre_level", {29'b0, level}, 32'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0043;
    step();
    bus.redirect_valid = 1'b0;
    chk("rd_level", {29'b0, level}, 32'd0);
    chk("rd_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rd_addr", {22'b0, bus.imem_addr}, 32'd16);
    step();
    chk("rd_head_pc", bus.out_pc, 32'h40);
    chk("rd_head_instr", bus.out_instr, 32'h1000_0010);
    chk("rd_head_pc4", bus.out_pc4, 32'h44);
    chk("rd_pflush", perf_flush, perf_exp(32'd1));
    chk("rd_pfetch", perf_fetch, perf_exp(32'd4));

    // Redirect coinciding with a handshake
    step();
    chk("rh_level", {29'b0, level}, 32'd2);
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    step();
    bus.redirect_valid = 1'b0;
    chk("rh_valid", {31'b0, bus.out_valid}, 32'd0);
    step();
    chk("rh_head_pc", bus.out_pc, 32'h100);
    chk("rh_head_instr", bus.out_instr, 32'h1000_0040);
    chk("rh_pflush", perf_flush, perf_exp(32'd2));

    // Reset outranks a simultaneous redirect
    bus.out_ready = 1'b0;
    step();
    chk("rr_pre_level", {29'b0, level}, 32'd2);
    reset              = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    step();
    chk("rr_level", {29'b0, level}, 32'd0);
    chk("rr_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rr_addr", {22'b0, bus.imem_addr}, 32'd0);
    chk("rr_pflush", perf_flush, 32'd0);
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    step();
    chk("rr_head_pc", bus.out_pc, 32'd0);
    chk("rr_head_valid", {31'b0, bus.out_valid}, 32'd1);

    // PC wrap at 2^32 and ROM aliasing
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", bus.out_instr, 32'h1000_03FF);
    chk("wrap_pc4", bus.out_pc4, 32'd0);
    chk("wrap_addr", {22'b0, bus.imem_addr}, 32'd0);
    step();
    chk("wrap_next_pc", bus.out_pc, 32'd0);
    chk("wrap_next_instr", bus.out_instr, 32'h1000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
